// File: rtl/es_iter_mul.sv
// es_iter_mul: iterative N-operand shift-add multiplier (mod 2^DATA_WIDTH).
// Each step multiplies the running product by the next operand, one bit per
// clock. Optional early exit ends a step once the multiplier runs out of set
// bits. A runtime cycle budget returns the last complete running product early.
module es_iter_mul #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 4,
  parameter int EARLY_EXIT = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             start,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
  input  logic [CNT_WIDTH-1:0]             cycle_budget,
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH-1:0]            bin_data_out,
  output logic                             truncated,
  output logic [CNT_WIDTH-1:0]             cycle_count
);
  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  // Operand used as the first multiplier (op[1], or op[0] when there is only one).
  localparam int FIRST = (NUM_INPUTS > 1) ? 1 : 0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
  localparam logic [BIT_W-1:0] BIT_END  = BIT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t                               state_q, state_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ops_q;
  logic [CNT_WIDTH-1:0]                 budget_q;
  logic [DATA_WIDTH-1:0]                acc_q, mcand_q, mplier_q, partial_q;
  logic [IDX_W-1:0]                     idx_q, idx_nxt;
  logic [BIT_W-1:0]                     bitcnt_q, bitcnt_nxt;

  logic [DATA_WIDTH-1:0] partial_nxt, mcand_sh, mplier_sh;
  logic [CNT_WIDTH-1:0]  cnt_nxt;
  logic                  step_end, last_step, budget_hit;

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // One shift-add step plus the step-end / budget conditions for this edge.
  always_comb begin
    partial_nxt = mplier_q[0] ? (partial_q + mcand_q) : partial_q;
    mcand_sh    = mcand_q << 1;
    mplier_sh   = mplier_q >> 1;
    bitcnt_nxt  = bitcnt_q + BIT_W'(1);
    cnt_nxt     = cycle_count + CNT_WIDTH'(1);
    idx_nxt     = idx_q + IDX_W'(1);
    step_end    = (bitcnt_nxt == BIT_END) || ((EARLY_EXIT != 0) && (mplier_sh == '0));
    last_step   = (idx_q == LAST_IDX);
    // A step completing on this edge takes priority; handled in the datapath.
    budget_hit  = (budget_q != '0) && (cnt_nxt == budget_q);
  end

  // Next-state logic: DONE always returns to IDLE, regardless of en.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en && start) state_d = (NUM_INPUTS == 1) ? S_DONE : S_MUL;
      S_MUL:   if (en && ((step_end && last_step) || budget_hit)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath: operand capture, shift-add iteration, result/flag update on exit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ops_q        <= '0;
      budget_q     <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      partial_q    <= '0;
      idx_q        <= '0;
      bitcnt_q     <= '0;
      cycle_count  <= '0;
      bin_data_out <= '0;
      truncated    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (en && start) begin
          ops_q       <= bin_data_in;
          budget_q    <= cycle_budget;
          acc_q       <= bin_data_in[DATA_WIDTH-1:0];
          mcand_q     <= bin_data_in[DATA_WIDTH-1:0];
          mplier_q    <= bin_data_in[FIRST*DATA_WIDTH +: DATA_WIDTH];
          partial_q   <= '0;
          idx_q       <= IDX_W'(FIRST);
          bitcnt_q    <= '0;
          cycle_count <= '0;
          if (NUM_INPUTS == 1) begin
            bin_data_out <= bin_data_in[DATA_WIDTH-1:0];
            truncated    <= 1'b0;
          end
        end
        S_MUL: if (en) begin
          cycle_count <= cnt_nxt;
          bitcnt_q    <= bitcnt_nxt;
          mcand_q     <= mcand_sh;
          mplier_q    <= mplier_sh;
          partial_q   <= partial_nxt;
          if (step_end) begin
            acc_q <= partial_nxt;
            if (last_step) begin
              bin_data_out <= partial_nxt;
              truncated    <= 1'b0;
            end else if (budget_hit) begin
              bin_data_out <= partial_nxt;
              truncated    <= 1'b1;
            end else begin
              idx_q     <= idx_nxt;
              mcand_q   <= partial_nxt;
              mplier_q  <= ops_q[idx_nxt];
              partial_q <= '0;
              bitcnt_q  <= '0;
            end
          end else if (budget_hit) begin
            bin_data_out <= acc_q;
            truncated    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
